// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline front end: fetch FSM states, hazard
// stall bit positions and the default bubble instruction.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DISCARD = 2'd2
  } fetch_state_e;

  localparam int STALL_PC   = 0;
  localparam int STALL_IFID = 1;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/ready bus; the fetch stage is the master.
interface fetch_stage_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic [DATA_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );

endinterface

// File: rtl/if_id_reg.sv
// Generic pipeline register with load / hold / bubble control; load wins
// over bubble, and neither asserted means hold.
module if_id_reg #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic              i_bubble,
  input  logic [DATA_W-1:0] i_instr,
  input  logic [ADDR_W-1:0] i_pc4,
  output logic [DATA_W-1:0] o_instr,
  output logic [ADDR_W-1:0] o_pc4,
  output logic              o_vld
);

  logic [DATA_W-1:0] r_instr_p1;
  logic [ADDR_W-1:0] r_pc4_p1;
  logic              r_vld_p1;

  // IF -> ID boundary; a bubble keeps the stale PC4 since valid=0 masks it
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_instr_p1 <= NOP_INSTR;
      r_pc4_p1   <= '0;
      r_vld_p1   <= 1'b0;
    end else if (i_load) begin
      r_instr_p1 <= i_instr;
      r_pc4_p1   <= i_pc4;
      r_vld_p1   <= 1'b1;
    end else if (i_bubble) begin
      r_instr_p1 <= NOP_INSTR;
      r_vld_p1   <= 1'b0;
    end
  end

  assign o_instr = r_instr_p1;
  assign o_pc4   = r_pc4_p1;
  assign o_vld   = r_vld_p1;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, runs the imem request/ready handshake and
// feeds the IF_ID register, honouring hazard stalls and branch/jump flushes.
module fetch_stage
  import pipe_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(NOP_INSTR_DEFAULT)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [1:0]        i_stall,
  input  logic              i_flush,
  input  logic              i_jump,
  input  logic [ADDR_W-1:0] i_branch_target,
  input  logic [ADDR_W-1:0] i_jump_target,
  fetch_stage_if.master     imem,
  output logic [DATA_W-1:0] o_if_id_instr,
  output logic [ADDR_W-1:0] o_if_id_pc4,
  output logic              o_if_id_valid,
  output logic [31:0]       o_fetch_count
);

  fetch_state_e      r_state;
  fetch_state_e      w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] r_pend;
  logic [ADDR_W-1:0] w_pend_nxt;
  logic [31:0]       r_cnt;
  logic              w_cnt_inc;
  logic              w_req;
  logic              w_load;
  logic              w_bubble;
  logic              w_stall_any;
  logic [ADDR_W-1:0] w_target;
  logic [ADDR_W-1:0] w_pc4;

  // Either stall bit freezes both PC and IF_ID so a dropped response is simply re-requested
  assign w_stall_any = i_stall[STALL_PC] | i_stall[STALL_IFID];
  assign w_target    = i_jump ? i_jump_target : i_branch_target;
  assign w_pc4       = r_pc + ADDR_W'(4);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_pend_nxt  = r_pend;
    w_req       = 1'b0;
    w_load      = 1'b0;
    w_bubble    = 1'b1;
    w_cnt_inc   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_state_nxt = ST_REQ;
      end
      ST_REQ: begin
        w_req = 1'b1;
        if (i_flush) begin
          if (imem.imem_ready) begin
            w_pc_nxt = w_target;
          end else begin
            // Outstanding request must keep its address; retire it in DISCARD
            w_pend_nxt  = w_target;
            w_state_nxt = ST_DISCARD;
          end
        end else if (w_stall_any) begin
          w_bubble = 1'b0;
        end else if (imem.imem_ready) begin
          w_load    = 1'b1;
          w_bubble  = 1'b0;
          w_pc_nxt  = w_pc4;
          w_cnt_inc = 1'b1;
        end
      end
      ST_DISCARD: begin
        w_req = 1'b1;
        if (i_flush) begin
          w_pend_nxt = w_target;
        end
        if (imem.imem_ready) begin
          w_pc_nxt    = i_flush ? w_target : r_pend;
          w_state_nxt = ST_REQ;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc   <= RESET_PC;
      r_pend <= '0;
      r_cnt  <= '0;
    end else begin
      r_pc   <= w_pc_nxt;
      r_pend <= w_pend_nxt;
      if (w_cnt_inc) begin
        r_cnt <= r_cnt + 32'd1;
      end
    end
  end

  assign imem.imem_req  = w_req;
  assign imem.imem_addr = r_pc;
  assign o_fetch_count  = r_cnt;

  if_id_reg #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_load   (w_load),
    .i_bubble (w_bubble),
    .i_instr  (imem.imem_rdata),
    .i_pc4    (w_pc4),
    .o_instr  (o_if_id_instr),
    .o_pc4    (o_if_id_pc4),
    .o_vld    (o_if_id_valid)
  );

endmodule
